// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product, one add/sub-and-shift
// per cycle through a single shared 32-bit adder/subtractor.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q_m1;
    logic [5:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_b;
    logic                 w_cin;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_ovf;
    logic                 w_sign;
    logic [WIDTH-1:0]     w_a_next;
    logic [WIDTH-1:0]     w_q_next;

    always_comb begin
        w_b   = '0;
        w_cin = 1'b0;
        unique case ({r_q[0], r_q_m1})
            2'b01: begin
                w_b   = r_m;
                w_cin = 1'b0;
            end
            2'b10: begin
                w_b   = ~r_m;
                w_cin = 1'b1;
            end
            default: begin
                w_b   = '0;
                w_cin = 1'b0;
            end
        endcase
    end

    // Shared adder; carry-out is not needed, only signed overflow.
    assign w_sum = r_a + w_b + WIDTH'(w_cin);
    assign w_ovf = (r_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    // True sign of the 33-bit result, so that M = -2^31 shifts in the right bit.
    assign w_sign   = w_sum[WIDTH-1] ^ w_ovf;
    assign w_a_next = {w_sign, w_sum[WIDTH-1:1]};
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_q_m1  <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a    <= w_a_next;
                    r_q    <= w_q_next;
                    r_q_m1 <= r_q[0];
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'(WIDTH - 1)) begin
                        r_product <= {w_a_next, w_q_next};
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: a cycle model predicts busy/done and a scoreboard
// queue holds the expected product of every accepted operand pair.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done = 0;
    int          m_cnt = 0;
    logic [63:0] m_product = '0;
    logic [63:0] exp_q[$];

    booth_seq_mult #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    // Cycle model: 33 busy cycles after acceptance, done in the last of them.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                exp_q.push_back(ref_mul(multiplicand, multiplier));
                m_cnt = 33;
            end
        end else begin
            m_cnt--;
        end
    end

    // Monitor sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_product = '0;
        end else begin
            if (m_cnt == 1) begin
                if (exp_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
                else m_product = exp_q.pop_front();
            end
            check("busy", 64'(busy), 64'(m_cnt != 0));
            check("done", 64'(done), 64'(m_cnt == 1));
            check("product", product, m_product);
            if (done) n_done++;
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            multiplicand = $urandom;
            multiplier = $urandom;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic mult(input logic [31:0] m, input logic [31:0] q, input logic [63:0] expv,
                        input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check(tag, product, expv);
        @(negedge clk);
        check({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        int          lat;
        int          done_base;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] first;

        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", {62'b0, busy, done}, 64'd0);
        check("rst_product", product, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        mult(32'h3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "m3xm5");
        mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");
        mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "maxxmax");
        mult(32'h0, 32'hDEAD_BEEF, 64'h0, "zero");
        mult(32'hFFFF_FFFF, 32'h1234_5678, 64'hFFFF_FFFF_EDCB_A988, "neg1");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            mult(a, b, ref_mul(a, b), "rand");
        end

        // start held high with operands changing every cycle: three acceptances.
        done_base = n_done;
        @(negedge clk);
        start = 1'b1;
        multiplicand = $urandom;
        multiplier = $urandom;
        for (int k = 1; k <= 102; k++) begin
            @(negedge clk);
            multiplicand = $urandom;
            multiplier = $urandom;
        end
        start = 1'b0;
        for (int k = 0; k < 40 && m_cnt != 0; k++) @(negedge clk);
        @(negedge clk);
        check("cont_dones", 64'(n_done - done_base), 64'd3);

        // Reset in the middle of 7x9.
        @(negedge clk);
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", {62'b0, busy, done}, 64'd0);
        check("midrst_product", product, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        done_base = n_done;
        repeat (40) @(negedge clk);
        check("midrst_nodone", 64'(n_done - done_base), 64'd0);
        mult(32'd7, 32'd9, 64'd63, "after_rst");

        // Start during DONE is ignored; start one cycle later is accepted.
        @(negedge clk);
        start = 1'b1;
        multiplicand = 32'hFFFE_1DC0;
        multiplier = 32'd654321;
        first = ref_mul(32'hFFFE_1DC0, 32'd654321);
        wait_done(lat);
        check("b2b_lat1", 64'(lat), 64'd33);
        check("b2b_first", product, first);
        start = 1'b1;
        multiplicand = 32'd5;
        multiplier = 32'd5;
        @(negedge clk);
        multiplicand = 32'd11;
        multiplier = 32'hFFFF_FFF3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_hold", product, first);
        wait_done(lat);
        check("b2b_lat2", 64'(lat), 64'd32);
        check("b2b_second", product, ref_mul(32'd11, 32'hFFFF_FFF3));
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-2 Booth multiplier controller for signed 32×32 → 64-bit multiplication. It sequences one shared 32-bit ripple-carry adder/subtractor (a, b, cin → sum, cout, overflow) through 32 add/subtract-and-shift iterations. It sits between a requesting unit (start/busy/done handshake) and the arithmetic datapath, and replaces a full combinational array multiplier where area matters more than latency.

## Interface

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the iteration counter is sized for it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; clears all state.
- start  input  1  request; sampled only when busy=0.
- multiplicand  input  32  signed operand M; sampled on the accepting edge.
- multiplier  input  32  signed operand Q; sampled on the accepting edge.
- busy  output  1  high from the accepting edge through the DONE cycle.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  64  signed result register; holds the last completed result.

## Operation

- Internal registers: M[31:0], A[31:0] (accumulator), Q[31:0], q_m1 (Q₋₁), cnt[5:0], state.
- States: IDLE, RUN, DONE.
- IDLE, start=1: load M←multiplicand, Q←multiplier, A←0, q_m1←0, cnt←0, then go to RUN. start=0: stay in IDLE.
- RUN: each cycle examines {Q[0], q_m1} and drives the adder:
  - 01: a=A, b=M, cin=0 (add).
  - 10: a=A, b=~M, cin=1 (subtract).
  - 00 and 11: a=A, b=0, cin=0 (pass).
- Arithmetic shift right of {sum, Q, q_m1} by one:
  - A←{s, sum[31:1]}, Q←{sum[0], Q[31:1]}, q_m1←Q[0].
  - The shift-in bit is s = sum[31] XOR overflow, the true sign of the 33-bit result. This is mandatory so that M = −2³¹ is handled correctly.
- cnt increments every RUN cycle. After the iteration with cnt=31, go to DONE.
- DONE: product←{A, Q} (registered on entry, i.e. the same edge that completes iteration 32), done=1, busy=1. Next state is always IDLE.
- start asserted while busy=1, including the DONE cycle, is ignored and not queued.
- The adder's cout is unused.

## Timing

- Reset values: busy=0, done=0, product=64'h0. State=IDLE; all internal registers 0.
- Let edge E0 be the rising edge at which start=1 and busy=0:
  - Operands are captured at E0, and busy=1 after E0.
  - Iterations complete at edges E1 through E32.
  - product is updated at E32, and done=1 during the cycle between E32 and E33.
  - busy=0 and done=0 after E33.
- Latency from accepting edge to the done pulse: 33 cycles. Throughput: one multiply per 34 cycles (start can next be accepted at E34).
- product changes only at completion edges. It is stable from E32 until the next completion or reset.
- rst_n low at any time, including mid-RUN or during DONE, immediately forces the reset values. The in-flight operation is discarded with no done pulse. After release, the first rising edge with rst_n=1 may accept a start.
- Operand inputs are don't-care except at the accepting edge.

## Test plan

- 3 × −5: start with M=32'h3, Q=32'hFFFF_FFFB → done exactly 33 cycles after acceptance, product=64'hFFFF_FFFF_FFFF_FFF1, busy low the following cycle.
- Extremes:
  - M=Q=32'h8000_0000 → product=64'h4000_0000_0000_0000, which exercises the overflow-corrected shift.
  - M=Q=32'h7FFF_FFFF → product=64'h3FFF_FFFF_0000_0001.
- Zero and identity:
  - 0 × 32'hDEAD_BEEF → product=0.
  - 32'hFFFF_FFFF × 32'h1234_5678 → product=64'hFFFF_FFFF_EDCB_A988.
- start held high continuously with changing operands → only operands present at accepting edges are used. done pulses every 34 cycles, and product matches each accepted pair.
- Reset mid-operation: assert rst_n=0 at iteration 15 of 7×9 → busy, done and product are 0 immediately. No done pulse follows. A new 7×9 after release gives product=64'd63.
- Back-to-back runs: issue a second start during the DONE cycle → it is ignored. A start one cycle later is accepted, and the first product is held until the second done.
